seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
- Parametrised, self-scanning multi-digit 7-segment driver; successor to the purely combinational 4-digit decoder, which needs an externally driven anode strobe.
- Owns the anode scan, refresh prescaler, per-digit ghost-blanking guard, tear-free double-buffered digit load, leading-zero blanking, per-digit blink and decimal points.
- Sits between the score/timer logic and the board's common-anode display pins.

Parameters:
- NUM_DIGITS, 4, digits driven (2..8).
- REFRESH_DIV, 100000, clk cycles per digit slot (>= BLANK_CYCLES+1).
- BLANK_CYCLES, 2000, cycles at the start of each slot with all anodes off.
- BLINK_FRAMES, 64, full scan frames per blink half-period (>= 1).
- HEX_EN, 0, 1 = codes 10..15 shown as A,b,C,d,E,F; 0 = codes 10..15 blank.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- digits_i  in  4*NUM_DIGITS  BCD/hex nibbles; nibble 0 = rightmost digit
- load  in  1  one-cycle strobe capturing digits_i
- dp_i  in  NUM_DIGITS  decimal point request per digit, 1 = lit, sampled live
- lz_en  in  1  leading-zero blanking enable, sampled live
- blink_mask  in  NUM_DIGITS  1 = digit blinks, sampled live
- AN  out  NUM_DIGITS  anode enables, active-low
- CA,CB,CC,CD,CE,CF,CG  out  1 each  segments, active-low
- DP  out  1  decimal point, active-low

Behaviour:
- Reset (async assert, sync release): AN all 1; CA..CG = 1; DP = 1. Prescaler, scan index, frame counter and blink phase = 0. Pending and active digit registers = 0. Pending flag = 0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. On the wrap edge, the scan index advances; NUM_DIGITS-1 wraps to 0, which is the frame boundary.
- Frame counter counts boundaries 0..BLINK_FRAMES-1. On its wrap the blink phase toggles.
- load captures digits_i into pending and sets the pending flag. A second load before a boundary overwrites pending.
- At a frame boundary with the flag set: active <= pending; flag cleared. If load coincides with the boundary edge, active <= digits_i directly and the flag ends cleared.
- The displayed digit never changes mid-frame.
- Digit i is blanked (segments and DP all 1, AN[i] still 0) when:
  - HEX_EN=0 and its code is > 9; or
  - lz_en=1, i != 0, and active nibbles i..NUM_DIGITS-1 are all 0; or
  - blink phase = 1 and blink_mask[i] = 1.
- All outputs are registered, one cycle behind the internal state. The output cycle after the state (index=k, prescaler=p) drives:
  - p < BLANK_CYCLES: AN all 1, segments 1, DP 1.
  - otherwise: AN one-cold at bit k, segments = decode(active nibble k), DP = ~dp_i[k] (forced 1 if blanked).
- Decode, as CA..CG active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - With HEX_EN=1: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Never more than one AN bit low in any cycle.
- Reset mid-slot forces all outputs off immediately. Scanning restarts at digit 0 with a blank guard.

Decomposition:
- Package seven_seg_pkg holds:
  - SEG_BLANK (7'b1111111);
  - the 16-entry segment pattern constant table;
  - the function computing the counter width from REFRESH_DIV and BLINK_FRAMES.
- One sub-module, seg_hex_decoder: combinational nibble + hex_en in, 7 segment bits out. It is also reusable by other displays.
- Scanner, prescaler and buffering stay in the top module.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2 unless stated):
- Assert rst_n=0 mid-slot -> AN=1111, CA..CG=1111111 and DP=1 within the same cycle, with no clk edge needed. Release -> first slot shows AN=1111 for 1 cycle, then AN=1110.
- load digits_i=16'h1234 while idle -> after the next boundary, 4-cycle slots show:
  - AN=1110 with seg 1001100 (4);
  - AN=1101 with 0000110 (3);
  - AN=1011 with 0010010 (2);
  - AN=0111 with 1001111 (1);
  - first cycle of every slot AN=1111.
- Active=16'h1234, then load 16'h5678 while index=1 -> digits 1..3 still show 3,2,1. Digit 0 shows 8 only after the wrap. Also load on the exact boundary edge -> the new value is shown in that frame.
- lz_en=1, active=16'h0070 -> slots 3 and 2 have AN low but segments 1111111. Digit 1 shows 0001111 and digit 0 shows 0000001. With lz_en=0, digits 3 and 2 show 0000001.
- blink_mask=0001 -> digit 0 is visible in frames 0-1, blank in frames 2-3, visible in frames 4-5. dp_i=0010 -> DP=0 only in the digit 1 slot after the guard.
- HEX_EN=0, digit code 4'hA -> 1111111. HEX_EN=1 -> 0001000. Across all tests, the bench checks that at most one AN bit is ever 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment display family.
// Segment vectors are active-low CA..CG, with CA in bit 6.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entries 10..15 are the hex letters A, b, C, d, E, F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic int counterWidth(input int refreshDiv, input int blinkFrames);
        int maxCount;
        maxCount = (refreshDiv > blinkFrames) ? refreshDiv : blinkFrames;
        return (maxCount > 2) ? $clog2(maxCount) : 1;
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to active-low seven-segment decoder.
// When hex display is disabled, codes above 9 are blanked.
module seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       hex_en_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_TABLE[nibble_i];
        if (!hex_en_i && (nibble_i > 4'd9)) begin
            seg_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Self-scanning multi-digit common-anode seven-segment driver.
// The driver provides a blanking guard, frame-synchronous digit loading, leading-zero blanking, blink, and decimal points.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000,
    parameter int BLINK_FRAMES = 64,
    parameter int HEX_EN       = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    lz_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    CA,
    output logic                    CB,
    output logic                    CC,
    output logic                    CD,
    output logic                    CE,
    output logic                    CF,
    output logic                    CG,
    output logic                    DP
);

    localparam int CNT_W = counterWidth(REFRESH_DIV, BLINK_FRAMES);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0]        prescaler_q, prescaler_d;
    logic [IDX_W-1:0]        scanIdx_q, scanIdx_d;
    logic [CNT_W-1:0]        frameCnt_q, frameCnt_d;
    logic                    blinkPhase_q, blinkPhase_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pendingFlag_q, pendingFlag_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;

    logic                    slotEnd;
    logic                    frameEnd;
    logic [3:0]              curNib;
    logic [6:0]              decSeg;
    logic [NUM_DIGITS-1:0]   lzBlank;
    logic                    zeroAbove;
    logic                    blanked;

    assign slotEnd  = (prescaler_q == CNT_W'(REFRESH_DIV - 1));
    assign frameEnd = slotEnd && (scanIdx_q == IDX_W'(NUM_DIGITS - 1));
    assign curNib   = active_q[4*scanIdx_q +: 4];

    always_comb begin
        prescaler_d   = prescaler_q + CNT_W'(1);
        scanIdx_d     = scanIdx_q;
        frameCnt_d    = frameCnt_q;
        blinkPhase_d  = blinkPhase_q;
        pending_d     = pending_q;
        pendingFlag_d = pendingFlag_q;
        active_d      = active_q;
        if (slotEnd) begin
            prescaler_d = '0;
            scanIdx_d   = frameEnd ? '0 : scanIdx_q + IDX_W'(1);
        end
        if (load) begin
            pending_d     = digits_i;
            pendingFlag_d = 1'b1;
        end
        // Active digits only move at the frame boundary, so a frame never tears.
        if (frameEnd) begin
            if (frameCnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                frameCnt_d   = '0;
                blinkPhase_d = ~blinkPhase_q;
            end else begin
                frameCnt_d = frameCnt_q + CNT_W'(1);
            end
            if (load) begin
                active_d      = digits_i;
                pendingFlag_d = 1'b0;
            end else if (pendingFlag_q) begin
                active_d      = pending_q;
                pendingFlag_d = 1'b0;
            end
        end
    end

    always_comb begin
        lzBlank   = '0;
        zeroAbove = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zeroAbove  = zeroAbove && (active_q[4*i +: 4] == 4'd0);
            lzBlank[i] = lz_en && zeroAbove;
        end
    end

    seg_hex_decoder u_decoder (
        .nibble_i (curNib),
        .hex_en_i (HEX_EN != 0),
        .seg_o    (decSeg)
    );

    always_comb begin
        blanked = ((HEX_EN == 0) && (curNib > 4'd9))
                || lzBlank[scanIdx_q]
                || (blinkPhase_q && blink_mask[scanIdx_q]);
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        // The guard at the start of each slot keeps the previous digit from ghosting.
        if (prescaler_q >= CNT_W'(BLANK_CYCLES)) begin
            an_d[scanIdx_q] = 1'b0;
            if (!blanked) begin
                seg_d = decSeg;
                dp_d  = ~dp_i[scanIdx_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q   <= '0;
            scanIdx_q     <= '0;
            frameCnt_q    <= '0;
            blinkPhase_q  <= 1'b0;
            pending_q     <= '0;
            pendingFlag_q <= 1'b0;
            active_q      <= '0;
            an_q          <= '1;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
        end else begin
            prescaler_q   <= prescaler_d;
            scanIdx_q     <= scanIdx_d;
            frameCnt_q    <= frameCnt_d;
            blinkPhase_q  <= blinkPhase_d;
            pending_q     <= pending_d;
            pendingFlag_q <= pendingFlag_d;
            active_q      <= active_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign AN = an_q;
    assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
    assign DP = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with 4 digits, 4-cycle slots, a 1-cycle guard, and 2-frame blink.
// Two instances share inputs: one with hex display disabled and one with hex display enabled.
module tb_seven_seg_scanner;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SA = 7'b0001000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_i;
    logic        load;
    logic [3:0]  dp_i;
    logic        lz_en;
    logic [3:0]  blink_mask;

    logic [3:0]  AN, ANh;
    logic        CA, CB, CC, CD, CE, CF, CG, DP;
    logic        CAh, CBh, CCh, CDh, CEh, CFh, CGh, DPh;

    int checkCount = 0;
    int passCount  = 0;
    int cycle      = -1;
    bit monEn      = 1'b0;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2), .HEX_EN(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits_i(digits_i), .load(load), .dp_i(dp_i),
        .lz_en(lz_en), .blink_mask(blink_mask), .AN(AN),
        .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG), .DP(DP)
    );

    seven_seg_scanner #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2), .HEX_EN(1)
    ) dutHex (
        .clk(clk), .rst_n(rst_n), .digits_i(digits_i), .load(load), .dp_i(dp_i),
        .lz_en(lz_en), .blink_mask(blink_mask), .AN(ANh),
        .CA(CAh), .CB(CBh), .CC(CCh), .CD(CDh), .CE(CEh), .CF(CFh), .CG(CGh), .DP(DPh)
    );

    // At most one anode may ever be driven low on either instance.
    always @(negedge clk) begin
        if (monEn) begin
            checkCount++;
            assert (($countones(~AN) <= 1) && ($countones(~ANh) <= 1)) passCount++;
            else $error("[TB] FAIL oneCold cycle %0d: observed AN=%b ANh=%b, expected at most one low bit",
                        cycle, AN, ANh);
        end
    end

    task automatic applyStimulus(input logic [15:0] digits, input logic loadV, input logic [3:0] dp,
                                 input logic lz, input logic [3:0] blink);
        digits_i   = digits;
        load       = loadV;
        dp_i       = dp;
        lz_en      = lz;
        blink_mask = blink;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expAn, input logic [6:0] expSeg,
                               input logic expDp);
        logic [11:0] obs, want;
        obs  = {AN, CA, CB, CC, CD, CE, CF, CG, DP};
        want = {expAn, expSeg, expDp};
        checkCount++;
        assert (obs === want) passCount++;
        else $error("[TB] FAIL %s cycle %0d: observed AN=%b seg=%b DP=%b, expected AN=%b seg=%b DP=%b",
                    tag, cycle, obs[11:8], obs[7:1], obs[0], expAn, expSeg, expDp);
    endtask

    task automatic checkHex(input string tag, input logic [3:0] expAn, input logic [6:0] expSeg,
                            input logic expDp);
        logic [11:0] obs, want;
        obs  = {ANh, CAh, CBh, CCh, CDh, CEh, CFh, CGh, DPh};
        want = {expAn, expSeg, expDp};
        checkCount++;
        assert (obs === want) passCount++;
        else $error("[TB] FAIL %s cycle %0d: observed AN=%b seg=%b DP=%b, expected AN=%b seg=%b DP=%b",
                    tag, cycle, obs[11:8], obs[7:1], obs[0], expAn, expSeg, expDp);
    endtask

    // segs packs digit 3..0 patterns; dps holds the expected DP level per digit.
    task automatic runCycles(input int n, input string tag, input logic [27:0] segs, input logic [3:0] dps);
        logic [3:0] an;
        int k;
        for (int i = 0; i < n; i++) begin
            stepCycle();
            k = (cycle / 4) % 4;
            if ((cycle % 4) == 0) begin
                checkOutput(tag, 4'b1111, SB, 1'b1);
            end else begin
                an    = 4'b1111;
                an[k] = 1'b0;
                checkOutput(tag, an, segs[k*7 +: 7], dps[k]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(16'h0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
        repeat (3) @(negedge clk);
        checkOutput("resetState", 4'b1111, SB, 1'b1);
        rst_n = 1'b1;
        cycle = -1;
        monEn = 1'b1;

        stepCycle();
        checkOutput("releaseGuard", 4'b1111, SB, 1'b1);
        stepCycle();
        checkOutput("releaseFirst", 4'b1110, S0, 1'b1);
        stepCycle();
        checkOutput("releaseSecond", 4'b1110, S0, 1'b1);

        // Reset must take effect mid-slot without waiting for a clock edge.
        #2 rst_n = 1'b0;
        #1 checkOutput("asyncReset", 4'b1111, SB, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle = -1;
        stepCycle();
        checkOutput("restartGuard", 4'b1111, SB, 1'b1);
        stepCycle();
        checkOutput("restartFirst", 4'b1110, S0, 1'b1);

        applyStimulus(16'h1234, 1'b1, 4'b0000, 1'b0, 4'b0000);
        runCycles(1, "frame0", {S0, S0, S0, S0}, 4'b1111);
        applyStimulus(16'h1234, 1'b0, 4'b0000, 1'b0, 4'b0000);
        runCycles(13, "frame0", {S0, S0, S0, S0}, 4'b1111);
        runCycles(16, "load1234", {S1, S2, S3, S4}, 4'b1111);

        runCycles(5, "midFrame", {S1, S2, S3, S4}, 4'b1111);
        applyStimulus(16'h5678, 1'b1, 4'b0000, 1'b0, 4'b0000);
        runCycles(1, "midFrame", {S1, S2, S3, S4}, 4'b1111);
        applyStimulus(16'h5678, 1'b0, 4'b0000, 1'b0, 4'b0000);
        runCycles(10, "midFrame", {S1, S2, S3, S4}, 4'b1111);
        runCycles(15, "load5678", {S5, S6, S7, S8}, 4'b1111);

        applyStimulus(16'h0070, 1'b1, 4'b0000, 1'b0, 4'b0000);
        runCycles(1, "load5678", {S5, S6, S7, S8}, 4'b1111);
        applyStimulus(16'h0070, 1'b0, 4'b0000, 1'b0, 4'b0000);
        runCycles(16, "edgeLoad", {S0, S0, S7, S0}, 4'b1111);

        applyStimulus(16'h0070, 1'b0, 4'b0010, 1'b1, 4'b0001);
        runCycles(16, "lzDpVisible", {SB, SB, S7, S0}, 4'b1101);
        runCycles(32, "blinkBlank", {SB, SB, S7, SB}, 4'b1101);
        runCycles(16, "blinkVisible", {SB, SB, S7, S0}, 4'b1101);

        applyStimulus(16'h000A, 1'b1, 4'b0001, 1'b0, 4'b0000);
        runCycles(1, "dpDigit0", {S0, S0, S7, S0}, 4'b1110);
        applyStimulus(16'h000A, 1'b0, 4'b0001, 1'b0, 4'b0000);
        runCycles(15, "dpDigit0", {S0, S0, S7, S0}, 4'b1110);
        runCycles(2, "hexOff", {S0, S0, S0, SB}, 4'b1111);
        checkHex("hexOn", 4'b1110, SA, 1'b0);
        runCycles(14, "hexOff", {S0, S0, S0, SB}, 4'b1111);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
